// File: rtl/ff_bank_multimode.sv
// WIDTH-bit bank of mode-selectable flip-flops (D/T/JK/SR) with per-bit change
// pulses and sticky flags for illegal S=R=1 inputs in SR mode.
module ff_bank_multimode #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_changed,
  output logic [WIDTH-1:0] sr_err_bits,
  output logic             sr_err
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] changed_reg, changed_next;
  logic [WIDTH-1:0] err_reg, err_next, err_set;

  // Next state of one bit; the S=R=1 case holds so q stays a known value.
  function automatic logic bit_next(input logic [1:0] m, input logic qb,
                                    input logic x, input logic y);
    logic r;
    r = qb;
    case (m)
      MODE_D:  r = x;
      MODE_T:  r = qb ^ x;
      MODE_JK: begin
        case ({x, y})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = ~qb;
          default: r = qb;
        endcase
      end
      default: begin
        case ({x, y})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          default: r = qb;
        endcase
      end
    endcase
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign q_next[gi]  = en ? bit_next(mode, q_reg[gi], a[gi], b[gi]) : q_reg[gi];
      assign err_set[gi] = en & (mode == MODE_SR) & a[gi] & b[gi];
    end
  endgenerate

  assign changed_next = q_next ^ q_reg;
  // A fresh set in the same cycle as clr_err survives for that bit.
  assign err_next     = (clr_err ? {WIDTH{1'b0}} : err_reg) | err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= RESET_VAL;
      changed_reg <= '0;
      err_reg     <= '0;
    end else begin
      q_reg       <= q_next;
      changed_reg <= changed_next;
      err_reg     <= err_next;
    end
  end

  assign q           = q_reg;
  assign q_changed   = changed_reg;
  assign sr_err_bits = err_reg;
  assign sr_err      = |err_reg;

endmodule
